// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman datapath blocks.
package dh_pkg;

  localparam int unsigned DW      = 16;
  localparam int unsigned RED_LAT = 2 * DW;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MUL   = 3'd2,
    RED   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Reducer latency for a given operand width: one quotient bit per cycle.
  function automatic int unsigned red_lat(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mod_reduce.sv
// Sequential restoring shift-subtract reducer: remainder of a 2W-bit dividend mod a W-bit modulus.
module mod_reduce
  import dh_pkg::*;
#(
  parameter int unsigned W = DW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   modulus,
  output logic [W-1:0]   remainder,
  output logic           rdone
);

  localparam int unsigned LAT = red_lat(W);
  localparam int unsigned CW  = $clog2(LAT + 1);
  localparam int unsigned PW  = 2 * W;

  logic [PW-1:0] sh;
  logic [CW-1:0] cnt;
  logic          active;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [W-1:0] step(input logic [W-1:0] r, input logic b, input logic [W-1:0] m);
    logic [W:0] t;
    t = {r, b};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[W-1:0];
  endfunction

  // The first bit is consumed on the start edge so rdone lands LAT cycles after start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remainder <= '0;
      sh        <= '0;
      cnt       <= '0;
      active    <= 1'b0;
      rdone     <= 1'b0;
    end else begin
      rdone <= 1'b0;
      if (start) begin
        remainder <= step('0, dividend[PW-1], modulus);
        sh        <= dividend << 1;
        cnt       <= CW'(1);
        active    <= 1'b1;
      end else if (active) begin
        remainder <= step(remainder, sh[PW-1], modulus);
        sh        <= sh << 1;
        cnt       <= cnt + CW'(1);
        if (cnt == CW'(LAT - 1)) begin
          active <= 1'b0;
          rdone  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/discrete_log.sv
// Brute-force discrete logarithm: smallest e with base^e mod modulus == target.
module discrete_log
  import dh_pkg::*;
#(
  parameter int unsigned W = DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] target,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] exponent,
  output logic         found,
  output logic         done,
  output logic         busy
);

  localparam int unsigned PW = 2 * W;

  state_t         state, state_d;
  logic [W-1:0]   b_q, t_q, m_q, acc, k;
  logic [W-1:0]   b_d, t_d, m_d, acc_d, k_d, exponent_d;
  logic           found_d, done_d, busy_d;
  logic           red_start_c;
  logic [PW-1:0]  prod_c;
  logic [W-1:0]   rem;
  logic           rdone;

  // Full-width product; the reducer registers it on the MUL edge.
  assign prod_c = PW'(acc) * PW'(b_q);

  mod_reduce #(.W(W)) u_reduce (
    .clk       (clk),
    .rst       (rst),
    .start     (red_start_c),
    .dividend  (prod_c),
    .modulus   (m_q),
    .remainder (rem),
    .rdone     (rdone)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      b_q      <= '0;
      t_q      <= '0;
      m_q      <= '0;
      acc      <= '0;
      k        <= '0;
      exponent <= '0;
      found    <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      b_q      <= b_d;
      t_q      <= t_d;
      m_q      <= m_d;
      acc      <= acc_d;
      k        <= k_d;
      exponent <= exponent_d;
      found    <= found_d;
      done     <= done_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_d     = state;
    b_d         = b_q;
    t_d         = t_q;
    m_d         = m_q;
    acc_d       = acc;
    k_d         = k;
    exponent_d  = exponent;
    found_d     = found;
    done_d      = done;
    busy_d      = busy;
    red_start_c = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          b_d        = base;
          t_d        = target;
          m_d        = modulus;
          exponent_d = '0;
          found_d    = 1'b0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          acc_d      = W'(1);
          k_d        = '0;
          if (modulus < W'(2) || base >= modulus || target >= modulus) state_d = DONE;
          else                                                          state_d = CHECK;
        end
      end
      CHECK: begin
        if (acc == t_q) begin
          found_d    = 1'b1;
          exponent_d = k;
          state_d    = DONE;
        end else if (k == m_q - W'(2)) begin
          state_d = DONE;
        end else begin
          state_d = MUL;
        end
      end
      MUL: begin
        red_start_c = 1'b1;
        state_d     = RED;
      end
      RED: begin
        if (rdone) begin
          acc_d   = rem;
          k_d     = k + W'(1);
          state_d = CHECK;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_discrete_log.sv
// Directed bench for discrete_log: results, done latency, busy/done exclusivity, reset.
module tb_discrete_log;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] base = '0;
  logic [W-1:0] target = '0;
  logic [W-1:0] modulus = '0;
  logic [W-1:0] exponent;
  logic         found, done, busy;

  int checks = 0;
  int failures = 0;
  int cyc, bad;

  discrete_log #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .target   (target),
    .modulus  (modulus),
    .exponent (exponent),
    .found    (found),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request, then count cycles until done; optionally pulse a second start mid-search.
  task automatic run(input logic [W-1:0] b, input logic [W-1:0] t, input logic [W-1:0] m,
                     input int pulse_at, output int ncyc, output int nbad);
    @(negedge clk);
    base = b; target = t; modulus = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = W'($urandom); target = W'($urandom); modulus = W'($urandom);
    ncyc = 0; nbad = 0;
    while (!done && ncyc < 2000) begin
      @(posedge clk); #1;
      ncyc++;
      if (done && busy) nbad++;
      if (!done && !busy) nbad++;
      if (ncyc == pulse_at) begin
        base = 16'd5; target = 16'd1; modulus = 16'd17; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_exponent", exponent, 0);
    chk("reset_found", found, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk); rst = 1'b1;

    // 3^4 = 81 = 13 mod 17
    run(16'd3, 16'd13, 16'd17, -1, cyc, bad);
    chk("t1_cycles", cyc, 138);
    chk("t1_found", found, 1);
    chk("t1_exponent", exponent, 4);
    chk("t1_busy_done", bad, 0);
    repeat (3) @(posedge clk); #1;
    chk("t1_done_held", done, 1);
    chk("t1_exp_held", exponent, 4);

    run(16'd5, 16'd1, 16'd17, -1, cyc, bad);
    chk("t2_cycles", cyc, 2);
    chk("t2_found", found, 1);
    chk("t2_exponent", exponent, 0);

    // 3 is outside the subgroup {1,4,16,13}
    run(16'd4, 16'd3, 16'd17, -1, cyc, bad);
    chk("t3_cycles", cyc, 512);
    chk("t3_found", found, 0);
    chk("t3_exponent", exponent, 0);
    chk("t3_busy_done", bad, 0);

    run(16'd0, 16'd0, 16'd1, -1, cyc, bad);
    chk("t4_mod1_cycles", cyc, 1);
    chk("t4_mod1_found", found, 0);

    run(16'd20, 16'd1, 16'd17, -1, cyc, bad);
    chk("t5_base_cycles", cyc, 1);
    chk("t5_base_found", found, 0);
    chk("t5_base_exponent", exponent, 0);

    // Second start mid-search must be ignored
    run(16'd3, 16'd13, 16'd17, 50, cyc, bad);
    chk("t6_cycles", cyc, 138);
    chk("t6_found", found, 1);
    chk("t6_exponent", exponent, 4);
    chk("t6_busy_done", bad, 0);

    // Reset mid-search, then re-run
    @(negedge clk);
    base = 16'd3; target = 16'd13; modulus = 16'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (60) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_exponent", exponent, 0);
    chk("rst_found", found, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run(16'd3, 16'd13, 16'd17, -1, cyc, bad);
    chk("t7_cycles", cyc, 138);
    chk("t7_found", found, 1);
    chk("t7_exponent", exponent, 4);
    chk("t7_busy_done", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
